// File: rtl/max7219_pkg.sv
// Shared definitions for the dual MAX7219 LED-matrix driver.
// Holds the chip register map, the power-up command ROM and the helper
// that packs an address/data pair into the 16-bit MAX7219 command format.
package max7219_pkg;

    // MAX7219 register addresses
    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DIGIT1    = 4'h2;
    localparam logic [3:0] REG_DIGIT2    = 4'h3;
    localparam logic [3:0] REG_DIGIT3    = 4'h4;
    localparam logic [3:0] REG_DIGIT4    = 4'h5;
    localparam logic [3:0] REG_DIGIT5    = 4'h6;
    localparam logic [3:0] REG_DIGIT6    = 4'h7;
    localparam logic [3:0] REG_DIGIT7    = 4'h8;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    localparam int INIT_LEN = 5;
    localparam int ROWS     = 8;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } max7219_cmd_t;

    // {4'h0, addr, data}, transmitted MSB first
    function automatic logic [15:0] pack_cmd(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

    // Power-up command ROM; every entry goes to both chips unchanged.
    function automatic max7219_cmd_t init_cmd(input logic [2:0] idx, input logic [3:0] intensity);
        max7219_cmd_t c;
        c = '{addr: REG_SHUTDOWN, data: 8'h01};
        case (idx)
            3'd0:    c = '{addr: REG_TEST,      data: 8'h00};
            3'd1:    c = '{addr: REG_SCANLIMIT, data: 8'h07};
            3'd2:    c = '{addr: REG_DECODE,    data: 8'h00};
            3'd3:    c = '{addr: REG_INTENSITY, data: {4'h0, intensity}};
            default: c = '{addr: REG_SHUTDOWN,  data: 8'h01};
        endcase
        return c;
    endfunction

    // Row index 0..7 -> digit register 1..8
    function automatic logic [3:0] digit_addr(input logic [2:0] row);
        logic [3:0] a;
        a = REG_NOOP;
        case (row)
            3'd0: a = REG_DIGIT0;
            3'd1: a = REG_DIGIT1;
            3'd2: a = REG_DIGIT2;
            3'd3: a = REG_DIGIT3;
            3'd4: a = REG_DIGIT4;
            3'd5: a = REG_DIGIT5;
            3'd6: a = REG_DIGIT6;
            3'd7: a = REG_DIGIT7;
            default: a = REG_NOOP;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/max7219_display_dual_if.sv
// Write-only 3-wire serial link to the MAX7219 chain.
//   sck  : serial clock, idle low
//   mosi : serial data, MSB first, sampled by the chip on sck rising
//   cs   : load / chip select, active low; chip latches on its rising edge
interface max7219_display_dual_if;
    logic sck;
    logic mosi;
    logic cs;

    modport master (output sck, output mosi, output cs);
    modport slave  (input  sck, input  mosi, input  cs);
endinterface

// File: rtl/max7219_spi_tx.sv
// 32-bit serial transmitter for a two-chip MAX7219 chain.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : a word is available; accepted when idle or in the last gap cycle
//   word       : 32-bit word, bit 31 first
//   sck/mosi/cs: serial link outputs (registered)
//   done       : high in the last gap cycle of a transaction
// Frame: LOAD (1) + 32 bits x (CLK_DIV low + CLK_DIV high) + TAIL (CLK_DIV) + GAP (CLK_DIV).
module max7219_spi_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] word,
    output logic        sck,
    output logic        mosi,
    output logic        cs,
    output logic        done
);

    localparam int              CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_LOAD  = 3'd1;
    localparam logic [2:0] PH_SHIFT = 3'd2;
    localparam logic [2:0] PH_TAIL  = 3'd3;
    localparam logic [2:0] PH_GAP   = 3'd4;

    logic [2:0]    ph;
    logic [CW-1:0] cnt;
    logic [4:0]    bit_left;
    logic [31:0]   shreg;
    logic          cnt_end;

    assign cnt_end = (cnt == CNT_LAST);
    assign done    = (ph == PH_GAP) && cnt_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph       <= PH_IDLE;
            cnt      <= '0;
            bit_left <= '0;
            cs       <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            case (ph)
                PH_IDLE: begin
                    if (start) begin
                        ph   <= PH_LOAD;
                        cs   <= 1'b0;
                        mosi <= word[31];
                    end
                end
                PH_LOAD: begin
                    ph       <= PH_SHIFT;
                    cnt      <= '0;
                    bit_left <= 5'd31;
                end
                PH_SHIFT: begin
                    if (cnt_end) begin
                        cnt <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                        end else begin
                            // Falling sck starts the next low phase; data moves only here.
                            sck <= 1'b0;
                            if (bit_left == 5'd0) begin
                                ph <= PH_TAIL;
                            end else begin
                                bit_left <= bit_left - 5'd1;
                                mosi     <= shreg[30];
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_TAIL: begin
                    if (cnt_end) begin
                        cnt <= '0;
                        ph  <= PH_GAP;
                        cs  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_GAP: begin
                    if (cnt_end) begin
                        cnt <= '0;
                        // Chain straight into the next word so transactions run back-to-back.
                        if (start) begin
                            ph   <= PH_LOAD;
                            cs   <= 1'b0;
                            mosi <= word[31];
                        end else begin
                            ph <= PH_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ph <= PH_IDLE;
            endcase
        end
    end

    // Shift data path carries no reset; it is reloaded with every accepted word.
    always_ff @(posedge clk) begin
        if (((ph == PH_IDLE) || done) && start) begin
            shreg <= word;
        end else if ((ph == PH_SHIFT) && cnt_end && sck && (bit_left != 5'd0)) begin
            shreg <= {shreg[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/max7219_display_dual.sv
// Continuous refresh driver for two daisy-chained MAX7219 8x8 matrices.
// After reset it sends the five-command init sequence once, then refreshes
// rows 1..8 of both displays forever from a per-frame snapshot of pixels.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   pixels     : [127:64] display 0 (nearest MOSI), [63:0] display 1
//   bus        : serial link (sck, mosi, cs), master side
//   finish     : one-cycle pulse in the last cycle of every row-8 transaction
module max7219_display_dual
    import max7219_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter logic [3:0] INTENSITY = 4'h7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [127:0]                  pixels,
    max7219_display_dual_if.master        bus,
    output logic                          finish
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_ROW  = 2'd2;

    // state/idx describe the transaction currently on the wire.
    // In ST_ROW, idx holds the row number minus one.
    logic [1:0]   state, nxt_state;
    logic [2:0]   idx, nxt_idx;
    logic         advance;
    logic         new_frame;
    logic         tx_done;
    logic [31:0]  tx_word;
    logic [127:0] snap;
    logic [127:0] src;
    logic [7:0]   d0, d1;
    logic [3:0]   row_addr;
    max7219_cmd_t cmd;
    logic         tx_sck, tx_mosi, tx_cs;

    function automatic logic [7:0] byte_at(input logic [127:0] v, input logic [3:0] b);
        return v[{b, 3'b000} +: 8];
    endfunction

    assign advance   = (state == ST_IDLE) || tx_done;
    assign new_frame = (nxt_state == ST_ROW) && (nxt_idx == 3'd0);

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        case (state)
            ST_IDLE: begin
                nxt_state = ST_INIT;
                nxt_idx   = 3'd0;
            end
            ST_INIT: begin
                if (idx == 3'(INIT_LEN - 1)) begin
                    nxt_state = ST_ROW;
                    nxt_idx   = 3'd0;
                end else begin
                    nxt_idx = idx + 3'd1;
                end
            end
            ST_ROW: begin
                nxt_idx = idx + 3'd1;   // row 8 wraps to row 1
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_idx   = 3'd0;
            end
        endcase
    end

    // Row 1 reads pixels directly: snap is loaded on that same edge, so the
    // whole frame (rows 1..8) sees one consistent image.
    always_comb begin
        cmd      = init_cmd(nxt_idx, INTENSITY);
        src      = new_frame ? pixels : snap;
        d0       = byte_at(src, 4'd15 - {1'b0, nxt_idx});
        d1       = byte_at(src, 4'd7  - {1'b0, nxt_idx});
        row_addr = digit_addr(nxt_idx);
        if (nxt_state == ST_ROW) begin
            // Display 1's command goes first so it shifts through to the far chip.
            tx_word = {pack_cmd(row_addr, d1), pack_cmd(row_addr, d0)};
        end else begin
            tx_word = {pack_cmd(cmd.addr, cmd.data), pack_cmd(cmd.addr, cmd.data)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= 3'd0;
        end else if (advance) begin
            state <= nxt_state;
            idx   <= nxt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (advance && new_frame) begin
            snap <= pixels;
        end
    end

    assign finish = tx_done && (state == ST_ROW) && (idx == 3'(ROWS - 1));

    max7219_spi_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (advance),
        .word  (tx_word),
        .sck   (tx_sck),
        .mosi  (tx_mosi),
        .cs    (tx_cs),
        .done  (tx_done)
    );

    assign bus.sck  = tx_sck;
    assign bus.mosi = tx_mosi;
    assign bus.cs   = tx_cs;

endmodule

// File: tb/tb_max7219_display_dual.sv
module tb_max7219_display_dual;

    localparam int         CLK_DIV   = 4;
    localparam logic [3:0] INTENSITY = 4'h7;
    localparam int         T         = 1 + 66 * CLK_DIV;   // 265
    localparam int         FIRST_FIN = 13 * T - 1;         // 3444
    localparam int         FRAME     = 8 * T;              // 2120

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] pixels;
    logic         finish;

    max7219_display_dual_if bus();

    max7219_display_dual #(
        .CLK_DIV   (CLK_DIV),
        .INTENSITY (INTENSITY)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pixels (pixels),
        .bus    (bus),
        .finish (finish)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         init_addr [5] = '{15, 11, 9, 10, 12};
    int         init_data [5] = '{0, 7, 0, int'(INTENSITY), 1};
    logic [7:0] frame_bytes [16];
    logic [31:0] exp_q [$];

    function automatic logic [15:0] cmd16(input int addr, input int data);
        return 16'(addr * 256 + data);
    endfunction

    function automatic logic [31:0] model_word(input int k);
        int r;
        if (k < 5) return {cmd16(init_addr[k], init_data[k]), cmd16(init_addr[k], init_data[k])};
        r = (k - 5) % 8 + 1;
        return {cmd16(r, int'(frame_bytes[8 + r - 1])), cmd16(r, int'(frame_bytes[r - 1]))};
    endfunction

    // Cycle bookkeeping and predictor: transaction k begins at cycle k*T.
    bit rst_at_edge = 1'b1;
    bit have_edge   = 1'b0;
    int cyc_next    = 0;
    int cur         = -1;

    always @(posedge clk) begin
        int k;
        have_edge   = 1'b1;
        rst_at_edge = rst_n;
        if (!rst_n) begin
            cyc_next = 0;
            cur      = -1;
            exp_q.delete();
        end else begin
            cur = cyc_next;
            cyc_next++;
            if (cur % T == 0) begin
                k = cur / T;
                if (k >= 5 && (k - 5) % 8 == 0)
                    for (int i = 0; i < 16; i++) frame_bytes[i] = pixels[127 - 8 * i -: 8];
                exp_q.push_back(model_word(k));
            end
        end
    end

    // ---------------- monitor ----------------
    logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
    bit          in_win = 1'b0, first_win = 1'b1;
    int          nbits = 0, low_run = 0, high_run = 0, gap_run = 0;
    int          words_done = 0, fin_pulses = 0;
    logic [31:0] word_acc = '0;

    always @(negedge clk) begin
        bit exp_fin;
        logic [31:0] exp_w;
        if (have_edge) begin
            if (!rst_at_edge) begin
                check("reset_outputs", {28'd0, bus.cs, bus.sck, bus.mosi, finish}, 32'h8);
                in_win    = 1'b0;
                first_win = 1'b1;
                gap_run   = 0;
            end else begin
                if (cur == 0) check("first_cs_fall", {31'd0, bus.cs}, 32'd0);

                exp_fin = (cur >= FIRST_FIN) && ((cur - FIRST_FIN) % FRAME == 0);
                if (exp_fin || finish !== 1'b0) begin
                    check("finish_pulse", {31'd0, finish}, {31'd0, exp_fin});
                    if (finish === 1'b1) fin_pulses++;
                end

                if (prev_cs && !bus.cs) begin
                    if (!first_win) check("cs_gap_ge_div", {31'd0, gap_run >= CLK_DIV}, 32'd1);
                    first_win = 1'b0;
                    in_win    = 1'b1;
                    nbits     = 0;
                    word_acc  = '0;
                    low_run   = 0;
                end

                if (in_win && !bus.cs) begin
                    if (!prev_sck && bus.sck) begin
                        check("mosi_stable_rise", {31'd0, bus.mosi}, {31'd0, prev_mosi});
                        if (nbits > 0) check("sck_low_len", low_run, CLK_DIV);
                        word_acc = {word_acc[30:0], bus.mosi};
                        nbits++;
                        high_run = 1;
                    end else if (prev_sck && bus.sck) begin
                        high_run++;
                        check("mosi_hold_high", {31'd0, bus.mosi}, {31'd0, prev_mosi});
                    end else if (prev_sck && !bus.sck) begin
                        check("sck_high_len", high_run, CLK_DIV);
                        low_run = 1;
                    end else begin
                        low_run++;
                    end
                end

                if (!prev_cs && bus.cs && in_win) begin
                    check("sck_rises_per_word", nbits, 32);
                    if (exp_q.size() == 0) begin
                        check("scoreboard_nonempty", 32'd0, 32'd1);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("word", word_acc, exp_w);
                    end
                    words_done++;
                    in_win = 1'b0;
                end

                if (bus.cs) gap_run++;
                else        gap_run = 0;
            end
            prev_cs   = bus.cs;
            prev_sck  = bus.sck;
            prev_mosi = bus.mosi;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cycle(input int c);
        int guard = 0;
        while (cur < c && guard < 50000) begin
            @(posedge clk); #2;
            guard++;
        end
        check("wait_cycle_reached", {31'd0, cur >= c}, 32'd1);
    endtask

    initial begin
        int k;
        pixels = 128'h0102030405060708_0102030405060708;
        rst_n  = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;

        // Frame 2, row 4: new image must wait for frame 3.
        wait_cycle(16 * T + 17);
        pixels = {64'hFF00_0000_0000_0000, 64'h0};

        for (int n = 0; n < 4; n++) begin
            wait_cycle(cur + int'($urandom_range(300, 1500)));
            pixels = {$urandom, $urandom, $urandom, $urandom};
        end
        wait_cycle(FIRST_FIN + 3 * FRAME + 100);

        // Abort a transaction while cs is low.
        k = cur / T + 1;
        wait_cycle(k * T + int'($urandom_range(2, T - 2 * CLK_DIV - 2)));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_cs_high", {31'd0, bus.cs}, 32'd1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        pixels = {$urandom, $urandom, $urandom, $urandom};

        wait_cycle(FIRST_FIN + FRAME / 2);
        pixels = {$urandom, $urandom, $urandom, $urandom};
        wait_cycle(FIRST_FIN + FRAME + 50);

        check("words_seen", {31'd0, words_done >= 50}, 32'd1);
        check("finish_pulses_seen", {31'd0, fin_pulses >= 5}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
